// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute/predictor signal bundle for branch_resolve_queue.
// master = fetch/execute/predictor side, slave = the queue itself.
interface branch_resolve_queue_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PCW   = 16
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic           pred_valid;
    logic [PCW-1:0] pred_pc;
    logic           pred_taken;
    logic           pred_ready;
    logic           res_valid;
    logic           res_taken;
    logic           res_ready;
    logic           flush;
    logic           bht_write;
    logic [PCW-1:0] bht_write_pc;
    logic           bht_taken;
    logic           mispredict;
    logic [CW-1:0]  count;

    modport master (
        output pred_valid, pred_pc, pred_taken, res_valid, res_taken, flush,
        input  pred_ready, res_ready, bht_write, bht_write_pc, bht_taken,
               mispredict, count
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, res_valid, res_taken, flush,
        output pred_ready, res_ready, bht_write, bht_write_pc, bht_taken,
               mispredict, count
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order branch resolve queue feeding the branch history predictor's training port.
// Define BRQ_STATS_EN to add saturating pop/mispredict statistics counters.
module branch_resolve_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PCW   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_resolve_queue_if.slave  brq
`ifdef BRQ_STATS_EN
    ,
    output logic [15:0]            stat_branches,
    output logic [15:0]            stat_mispredicts
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [PCW-1:0]   pc_mem_q [DEPTH];
    logic [DEPTH-1:0] tk_mem_q;

    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic           bw_q, bt_q, mis_q;
    logic [PCW-1:0] bpc_q;

    logic push, pop, mis_now, head_taken;

    always_comb begin
        brq.pred_ready = (count_q != CW'(DEPTH));
        brq.res_ready  = (count_q != '0) && !brq.flush;
        head_taken     = tk_mem_q[head_q];
        pop            = brq.res_valid && brq.res_ready;
        mis_now        = pop && (brq.res_taken != head_taken);
        push           = brq.pred_valid && brq.pred_ready && !brq.flush && !mis_now;

        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        // A mispredict squashes everything younger, including a same-cycle push.
        if (mis_now || brq.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop)  head_d = head_q + 1'b1;
            if (push) tail_d = tail_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[tail_q] <= brq.pred_pc;
            tk_mem_q[tail_q] <= brq.pred_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            bw_q    <= 1'b0;
            bpc_q   <= '0;
            bt_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            bw_q    <= pop;
            bpc_q   <= pop ? pc_mem_q[head_q] : '0;
            bt_q    <= pop && brq.res_taken;
            mis_q   <= mis_now;
        end
    end

    assign brq.bht_write    = bw_q;
    assign brq.bht_write_pc = bpc_q;
    assign brq.bht_taken    = bt_q;
    assign brq.mispredict   = mis_q;
    assign brq.count        = count_q;

`ifdef BRQ_STATS_EN
    logic [15:0] stat_br_q, stat_mis_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (pop && (stat_br_q != '1))
                stat_br_q <= stat_br_q + 16'd1;
            if (mis_now && (stat_mis_q != '1))
                stat_mis_q <= stat_mis_q + 16'd1;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: vector table plus scoreboarded sequences.
module tb_branch_resolve_queue;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PCW   = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_queue_if #(.DEPTH(DEPTH), .PCW(PCW)) brq ();

`ifdef BRQ_STATS_EN
    logic [15:0] stat_br, stat_mis;
`endif

    branch_resolve_queue #(.DEPTH(DEPTH), .PCW(PCW)) dut (
        .clk   (clk),
        .reset (reset),
        .brq   (brq)
`ifdef BRQ_STATS_EN
        ,
        .stat_branches    (stat_br),
        .stat_mispredicts (stat_mis)
`endif
    );

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic           taken;
    } ent_t;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic           taken;
        logic           mis;
    } res_t;

    typedef struct {
        logic           pv;
        logic [PCW-1:0] pc;
        logic           pt;
        logic           rv;
        logic           rt;
        logic           fl;
        int             cnt;
        logic           mis;
    } vec_t;

    ent_t mq[$];
    res_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mdl_br  = 0;
    int   mdl_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; model decides what the queue must do, scoreboard checks outputs.
    task automatic cycle(input logic pv, input logic [PCW-1:0] pc, input logic pt,
                         input logic rv, input logic rt, input logic fl);
        logic pr, rr, pop, mis, push;
        res_t exp;
        brq.pred_valid = pv;
        brq.pred_pc    = pc;
        brq.pred_taken = pt;
        brq.res_valid  = rv;
        brq.res_taken  = rt;
        brq.flush      = fl;
        #1;
        pr = (mq.size() != DEPTH);
        rr = (mq.size() != 0) && !fl;
        chk("pred_ready", 32'(brq.pred_ready), 32'(pr));
        chk("res_ready", 32'(brq.res_ready), 32'(rr));
        pop = rv && rr;
        mis = 1'b0;
        if (pop) begin
            mis = (mq[0].taken != rt);
            sb.push_back('{pc: mq[0].pc, taken: rt, mis: mis});
            void'(mq.pop_front());
            if (mdl_br < 16'hFFFF) mdl_br++;
            if (mis && mdl_mis < 16'hFFFF) mdl_mis++;
        end
        push = pv && pr && !fl && !mis;
        if (mis || fl) mq.delete();
        if (push) mq.push_back('{pc: pc, taken: pt});
        @(posedge clk);
        #1;
        brq.pred_valid = 1'b0;
        brq.res_valid  = 1'b0;
        brq.flush      = 1'b0;
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk("bht_write", 32'(brq.bht_write), 32'd1);
            chk("bht_write_pc", 32'(brq.bht_write_pc), 32'(exp.pc));
            chk("bht_taken", 32'(brq.bht_taken), 32'(exp.taken));
            chk("mispredict", 32'(brq.mispredict), 32'(exp.mis));
        end else begin
            chk("bht_write_idle", 32'(brq.bht_write), 32'd0);
            chk("mispredict_idle", 32'(brq.mispredict), 32'd0);
        end
        chk("count", 32'(brq.count), 32'(mq.size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [11];
        logic t;

        vt[0]  = '{1'b1, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[1]  = '{1'b1, 16'h0104, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0};
        vt[2]  = '{1'b1, 16'h0108, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0};
        vt[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 2, 1'b0};
        vt[4]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0};
        vt[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0};
        vt[6]  = '{1'b1, 16'h0200, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vt[7]  = '{1'b1, 16'h0204, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0};
        vt[8]  = '{1'b1, 16'h0208, 1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b0};
        vt[9]  = '{1'b1, 16'h020C, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0};
        vt[10] = '{1'b1, 16'h0210, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1};

        reset          = 1'b1;
        brq.pred_valid = 1'b0;
        brq.pred_pc    = '0;
        brq.pred_taken = 1'b0;
        brq.res_valid  = 1'b0;
        brq.res_taken  = 1'b0;
        brq.flush      = 1'b0;
        #12;
        chk("rst_bht_write", 32'(brq.bht_write), 32'd0);
        chk("rst_bht_pc", 32'(brq.bht_write_pc), 32'd0);
        chk("rst_bht_taken", 32'(brq.bht_taken), 32'd0);
        chk("rst_mispredict", 32'(brq.mispredict), 32'd0);
        chk("rst_count", 32'(brq.count), 32'd0);
        chk("rst_pred_ready", 32'(brq.pred_ready), 32'd1);
        chk("rst_res_ready", 32'(brq.res_ready), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic pushes, in-order resolutions, head mispredict with dropped push.
        for (int unsigned i = 0; i < 11; i++) begin
            cycle(vt[i].pv, vt[i].pc, vt[i].pt, vt[i].rv, vt[i].rt, vt[i].fl);
            chk("tbl_count", 32'(brq.count), 32'(vt[i].cnt));
            chk("tbl_mispredict", 32'(brq.mispredict), 32'(vt[i].mis));
            if (i == 2) begin
                #1;
                chk("three_pred_ready", 32'(brq.pred_ready), 32'd1);
                chk("three_res_ready", 32'(brq.res_ready), 32'd1);
            end
            if (i == 10) chk("mis_bht_taken", 32'(brq.bht_taken), 32'd0);
        end

        // Full queue: no full-bypass, then wrap the pointers.
        for (int unsigned i = 0; i < DEPTH; i++)
            cycle(1'b1, PCW'(16'h1000 + i * 4), i[0], 1'b0, 1'b0, 1'b0);
        #1;
        chk("full_pred_ready", 32'(brq.pred_ready), 32'd0);
        cycle(1'b1, 16'h2000, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("full_pop_count", 32'(brq.count), 32'd7);
        for (int unsigned i = 0; i < 8; i++) begin
            t = mq[0].taken;
            cycle(1'b1, PCW'(16'h3000 + i * 4), i[0], 1'b1, t, 1'b0);
        end
        for (int unsigned i = 0; i < 7; i++) begin
            t = mq[0].taken;
            cycle(1'b0, '0, 1'b0, 1'b1, t, 1'b0);
        end
        chk("drain_count", 32'(brq.count), 32'd0);

        // Flush with five entries and a resolve pending.
        for (int unsigned i = 0; i < 5; i++)
            cycle(1'b1, PCW'(16'h4000 + i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h4100, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("flush_count", 32'(brq.count), 32'd0);
        chk("flush_bht_write", 32'(brq.bht_write), 32'd0);

        // Reset while a training pulse is outstanding.
        cycle(1'b1, 16'h5000, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h5004, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_bht_write", 32'(brq.bht_write), 32'd0);
        chk("midrst_bht_pc", 32'(brq.bht_write_pc), 32'd0);
        chk("midrst_bht_taken", 32'(brq.bht_taken), 32'd0);
        chk("midrst_mispredict", 32'(brq.mispredict), 32'd0);
        chk("midrst_count", 32'(brq.count), 32'd0);
        chk("midrst_pred_ready", 32'(brq.pred_ready), 32'd1);
        chk("midrst_res_ready", 32'(brq.res_ready), 32'd0);
        mq.delete();
        sb.delete();
        mdl_br  = 0;
        mdl_mis = 0;
        reset = 1'b0;
        #1;
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef BRQ_STATS_EN
        // 10 pops, 3 of them mispredicted.
        for (int unsigned r = 0; r < 2; r++) begin
            for (int unsigned i = 0; i < 4; i++)
                cycle(1'b1, PCW'(16'h6000 + i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
            for (int unsigned i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        cycle(1'b1, 16'h7000, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h7004, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("stat_branches", 32'(stat_br), 32'd10);
        chk("stat_mispredicts", 32'(stat_mis), 32'd3);
        chk("stat_model_br", 32'(stat_br), 32'(mdl_br));

        force dut.stat_br_q  = 16'hFFFE;
        force dut.stat_mis_q = 16'hFFFE;
        #1;
        release dut.stat_br_q;
        release dut.stat_mis_q;
        mdl_br  = 16'hFFFE;
        mdl_mis = 16'hFFFE;
        for (int unsigned i = 0; i < 3; i++) begin
            cycle(1'b1, PCW'(16'h8000 + i * 4), 1'b1, 1'b0, 1'b0, 1'b0);
            cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        chk("stat_br_sat", 32'(stat_br), 32'h0000FFFF);
        chk("stat_mis_sat", 32'(stat_mis), 32'h0000FFFF);
        chk("stat_mis_model", 32'(stat_mis), 32'(mdl_mis));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
